// File: rtl/drac_pkg.sv
// drac_pkg
//   Shared definitions for the tile reset controller: global and per-hart
//   FSM state encodings, and the legal ranges of the controller parameters.
package drac_pkg;

    typedef enum logic [1:0] {
        G_WAKE    = 2'd0,
        G_STAGGER = 2'd1,
        G_RUN     = 2'd2
    } glb_state_e;

    typedef enum logic [1:0] {
        H_HOLD = 2'd0,
        H_RUN  = 2'd1,
        H_SRST = 2'd2
    } hart_state_e;

    localparam int NHARTS_MIN       = 1;
    localparam int NHARTS_MAX       = 8;
    localparam int WAKE_CNT_W_MIN   = 2;
    localparam int WAKE_CNT_W_MAX   = 24;
    localparam int STAGGER_MIN      = 1;
    localparam int STAGGER_MAX      = 255;
    localparam int SOFT_RST_MIN     = 1;
    localparam int SOFT_RST_MAX     = 255;

endpackage

// File: rtl/drac_hart_rst_fsm.sv
// drac_hart_rst_fsm
//   Reset sequencer for one hart: waits for the global release, then serves
//   soft-reset requests by holding the hart in reset for SoftRstCycles cycles.
//   Ports:
//     clk_i          clock
//     reset_l        async active-low reset
//     release_i      one-cycle power-on release strobe from the global FSM
//     soft_rst_req_i soft-reset request level (rising edge acts)
//     hart_rstn_o    registered active-low hart reset
//     soft_rst_ack_o one-cycle pulse when a soft reset completes
//
//   state  | meaning
//   H_HOLD | held in reset after power-on, waiting for release_i
//   H_RUN  | hart running, soft-reset requests accepted
//   H_SRST | soft reset in progress, counting down
module drac_hart_rst_fsm
    import drac_pkg::*;
#(
    parameter int SoftRstCycles = 8
) (
    input  logic clk_i,
    input  logic reset_l,
    input  logic release_i,
    input  logic soft_rst_req_i,
    output logic hart_rstn_o,
    output logic soft_rst_ack_o
);

    localparam int CNT_W = $clog2(SoftRstCycles + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SoftRstCycles - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    hart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q;
    logic             rstn_q, rstn_d;
    logic             ack_q, ack_d;
    logic             req_rise;

    assign req_rise = soft_rst_req_i & ~req_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        case (state_q)
            H_HOLD: begin
                if (release_i) state_d = H_RUN;
            end
            H_RUN: begin
                if (req_rise) begin
                    state_d = H_SRST;
                    cnt_d   = CNT_LOAD;
                end
            end
            H_SRST: begin
                if (cnt_q == '0) begin
                    state_d = H_RUN;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = H_HOLD;
        endcase
        // Output flop follows the next state so the release lands on the
        // same edge as the state change.
        rstn_d = (state_d == H_RUN);
    end

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= H_HOLD;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            rstn_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= soft_rst_req_i;
            rstn_q  <= rstn_d;
            ack_q   <= ack_d;
        end
    end

    assign hart_rstn_o    = rstn_q;
    assign soft_rst_ack_o = ack_q;

endmodule

// File: rtl/drac_tile_rst_ctrl.sv
// drac_tile_rst_ctrl
//   Tile reset controller: after reset_l deassertion waits 2^(WakeCntWidth-1)
//   cycles, then releases the harts one by one StaggerCycles apart. Each hart
//   can afterwards be soft-reset independently.
//   Ports:
//     clk_i          clock
//     reset_l        async active-low reset
//     spc_grst_l     registered copy of reset_l
//     hart_rstn_o    per-hart active-low core reset
//     soft_rst_req_i per-hart soft-reset request
//     soft_rst_ack_o per-hart soft-reset completion pulse
//     all_awake_o    every hart released since power-on
//
//   state     | meaning
//   G_WAKE    | wake-up counter running, all harts held
//   G_STAGGER | releasing harts 1..NHarts-1 at StaggerCycles spacing
//   G_RUN     | all harts released; terminal until reset
module drac_tile_rst_ctrl
    import drac_pkg::*;
#(
    parameter int NHarts        = 1,
    parameter int WakeCntWidth  = 16,
    parameter int StaggerCycles = 4,
    parameter int SoftRstCycles = 8
) (
    input  logic              clk_i,
    input  logic              reset_l,
    output logic              spc_grst_l,
    output logic [NHarts-1:0] hart_rstn_o,
    input  logic [NHarts-1:0] soft_rst_req_i,
    output logic [NHarts-1:0] soft_rst_ack_o,
    output logic              all_awake_o
);

    if (NHarts < NHARTS_MIN || NHarts > NHARTS_MAX) begin : g_bad_nharts
        $error("drac_tile_rst_ctrl: NHarts out of range");
    end
    if (WakeCntWidth < WAKE_CNT_W_MIN || WakeCntWidth > WAKE_CNT_W_MAX) begin : g_bad_wake
        $error("drac_tile_rst_ctrl: WakeCntWidth out of range");
    end
    if (StaggerCycles < STAGGER_MIN || StaggerCycles > STAGGER_MAX) begin : g_bad_stagger
        $error("drac_tile_rst_ctrl: StaggerCycles out of range");
    end
    if (SoftRstCycles < SOFT_RST_MIN || SoftRstCycles > SOFT_RST_MAX) begin : g_bad_soft
        $error("drac_tile_rst_ctrl: SoftRstCycles out of range");
    end

    localparam int STG_W = $clog2(StaggerCycles + 1);
    localparam int IDX_W = 4;
    localparam logic [STG_W-1:0]        STG_LOAD = STG_W'(StaggerCycles - 1);
    localparam logic [STG_W-1:0]        STG_ONE  = 1;
    localparam logic [IDX_W-1:0]        IDX_ONE  = 1;
    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(NHarts - 1);
    localparam logic [WakeCntWidth-1:0] WAKE_ONE = 1;

    glb_state_e              glb_q, glb_d;
    logic [WakeCntWidth-1:0] wake_cnt_q, wake_cnt_d;
    logic [STG_W-1:0]        stg_cnt_q, stg_cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    all_awake_q, all_awake_d;
    logic                    grst_q;
    logic                    wake_done;
    logic [NHarts-1:0]       release_vec;

    // Saturates once the MSB is set; that MSB is the wake-done flag.
    assign wake_done  = wake_cnt_q[WakeCntWidth-1];
    assign wake_cnt_d = wake_done ? wake_cnt_q : wake_cnt_q + WAKE_ONE;

    always_comb begin
        glb_d       = glb_q;
        stg_cnt_d   = stg_cnt_q;
        idx_d       = idx_q;
        all_awake_d = all_awake_q;
        release_vec = '0;
        case (glb_q)
            G_WAKE: begin
                if (wake_done) begin
                    release_vec[0] = 1'b1;
                    if (NHarts == 1) begin
                        glb_d       = G_RUN;
                        all_awake_d = 1'b1;
                    end else begin
                        glb_d     = G_STAGGER;
                        idx_d     = IDX_ONE;
                        stg_cnt_d = STG_LOAD;
                    end
                end
            end
            G_STAGGER: begin
                if (stg_cnt_q == '0) begin
                    for (int i = 0; i < NHarts; i++) begin
                        if (idx_q == IDX_W'(i)) release_vec[i] = 1'b1;
                    end
                    if (idx_q == IDX_LAST) begin
                        glb_d       = G_RUN;
                        all_awake_d = 1'b1;
                    end else begin
                        idx_d     = idx_q + IDX_ONE;
                        stg_cnt_d = STG_LOAD;
                    end
                end else begin
                    stg_cnt_d = stg_cnt_q - STG_ONE;
                end
            end
            G_RUN: ;
            default: glb_d = G_WAKE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            glb_q       <= G_WAKE;
            wake_cnt_q  <= '0;
            stg_cnt_q   <= '0;
            idx_q       <= '0;
            all_awake_q <= 1'b0;
            grst_q      <= 1'b0;
        end else begin
            glb_q       <= glb_d;
            wake_cnt_q  <= wake_cnt_d;
            stg_cnt_q   <= stg_cnt_d;
            idx_q       <= idx_d;
            all_awake_q <= all_awake_d;
            grst_q      <= 1'b1;
        end
    end

    for (genvar g = 0; g < NHarts; g++) begin : g_hart
        drac_hart_rst_fsm #(
            .SoftRstCycles(SoftRstCycles)
        ) u_hart (
            .clk_i         (clk_i),
            .reset_l       (reset_l),
            .release_i     (release_vec[g]),
            .soft_rst_req_i(soft_rst_req_i[g]),
            .hart_rstn_o   (hart_rstn_o[g]),
            .soft_rst_ack_o(soft_rst_ack_o[g])
        );
    end

    assign spc_grst_l  = grst_q;
    assign all_awake_o = all_awake_q;

endmodule

// File: tb/tb_drac_tile_rst_ctrl.sv
// tb_drac_tile_rst_ctrl
//   Directed bench: a 3-hart instance (WakeCntWidth=4, StaggerCycles=2,
//   SoftRstCycles=3) and a 1-hart instance (StaggerCycles=255) share clock
//   and reset. Expected values are hand-derived edge numbers, counted from
//   the first rising edge after reset_l deassertion.
module tb_drac_tile_rst_ctrl;

    logic       clk_i = 1'b0;
    logic       reset_l = 1'b0;
    logic       spc_grst_l;
    logic [2:0] hart_rstn_o;
    logic [2:0] soft_rst_req_i = '0;
    logic [2:0] soft_rst_ack_o;
    logic       all_awake_o;

    logic       spc_grst_l_1;
    logic [0:0] hart_rstn_o_1;
    logic [0:0] soft_rst_req_i_1 = '0;
    logic [0:0] soft_rst_ack_o_1;
    logic       all_awake_o_1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_i = ~clk_i;

    drac_tile_rst_ctrl #(
        .NHarts(3), .WakeCntWidth(4), .StaggerCycles(2), .SoftRstCycles(3)
    ) dut (
        .clk_i         (clk_i),
        .reset_l       (reset_l),
        .spc_grst_l    (spc_grst_l),
        .hart_rstn_o   (hart_rstn_o),
        .soft_rst_req_i(soft_rst_req_i),
        .soft_rst_ack_o(soft_rst_ack_o),
        .all_awake_o   (all_awake_o)
    );

    drac_tile_rst_ctrl #(
        .NHarts(1), .WakeCntWidth(4), .StaggerCycles(255), .SoftRstCycles(8)
    ) dut1 (
        .clk_i         (clk_i),
        .reset_l       (reset_l),
        .spc_grst_l    (spc_grst_l_1),
        .hart_rstn_o   (hart_rstn_o_1),
        .soft_rst_req_i(soft_rst_req_i_1),
        .soft_rst_ack_o(soft_rst_ack_o_1),
        .all_awake_o   (all_awake_o_1)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Hand-derived expectations for the 3-hart instance with the directed
    // requests below: releases at 9/11/13, hart 1 soft reset accepted at 20,
    // harts 0 and 2 accepted together at 30.
    function automatic logic [7:0] exp_rstn(input int n);
        logic [2:0] r;
        r[0] = (n >= 9)  && !(n >= 30 && n <= 32);
        r[1] = (n >= 11) && !(n >= 20 && n <= 22);
        r[2] = (n >= 13) && !(n >= 30 && n <= 32);
        return {5'b0, r};
    endfunction

    function automatic logic [7:0] exp_ack(input int n);
        if (n == 23) return 8'b010;
        if (n == 33) return 8'b101;
        return 8'b000;
    endfunction

    task automatic check_edge(input int n);
        chk($sformatf("rstn@%0d", n),   hart_rstn_o,    exp_rstn(n));
        chk($sformatf("ack@%0d", n),    soft_rst_ack_o, exp_ack(n));
        chk($sformatf("awake@%0d", n),  all_awake_o,    {7'b0, n >= 13});
        chk($sformatf("grst@%0d", n),   spc_grst_l,     8'd1);
        chk($sformatf("rstn1@%0d", n),  hart_rstn_o_1,  {7'b0, n >= 9});
        chk($sformatf("awake1@%0d", n), all_awake_o_1,  {7'b0, n >= 9});
        chk($sformatf("ack1@%0d", n),   soft_rst_ack_o_1, 8'd0);
    endtask

    // Drives values to be sampled at edge n+1.
    task automatic apply_stim(input int n);
        case (n)
            9:  soft_rst_req_i[2] = 1'b1;  // hart 2 still in HOLD: ignored
            19: soft_rst_req_i[1] = 1'b1;  // rise sampled at edge 20
            20: soft_rst_req_i[1] = 1'b0;
            21: soft_rst_req_i[1] = 1'b1;  // rise during SRST: ignored, held past completion
            25: begin
                soft_rst_req_i[1] = 1'b0;
                soft_rst_req_i[2] = 1'b0;
            end
            29: begin
                soft_rst_req_i[0] = 1'b1;
                soft_rst_req_i[2] = 1'b1;
            end
            default: ;
        endcase
    endtask

    task automatic run_edges(input int last, input bit stim);
        for (int n = 1; n <= last; n++) begin
            tick();
            check_edge(n);
            if (stim) apply_stim(n);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rstn"},   hart_rstn_o,    8'd0);
        chk({tag, "_ack"},    soft_rst_ack_o, 8'd0);
        chk({tag, "_awake"},  all_awake_o,    8'd0);
        chk({tag, "_grst"},   spc_grst_l,     8'd0);
        chk({tag, "_rstn1"},  hart_rstn_o_1,  8'd0);
        chk({tag, "_awake1"}, all_awake_o_1,  8'd0);
        chk({tag, "_grst1"},  spc_grst_l_1,   8'd0);
    endtask

    task automatic reset_seq(input string tag);
        soft_rst_req_i = '0;
        reset_l = 1'b0;
        repeat (3) tick();
        check_zero(tag);
        reset_l = 1'b1;
    endtask

    initial begin
        reset_seq("por");
        run_edges(40, 1'b1);

        reset_seq("por2");
        run_edges(12, 1'b0);
        reset_l = 1'b0;
        #1;
        check_zero("midrst");
        repeat (2) tick();
        check_zero("midrst_hold");
        reset_l = 1'b1;
        run_edges(14, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/drac_tile_rst_ctrl.md
DRAC_TILE_RST_CTRL -- requirements
Module: drac_tile_rst_ctrl

Interface
REQ-001 SHALL have parameter NHarts, default 1, number of hart reset domains (legal 1..8).
REQ-002 SHALL have parameter WakeCntWidth, default 16, wake-up counter width (legal 2..24).
REQ-003 SHALL have parameter StaggerCycles, default 4, cycles between successive hart releases (legal 1..255).
REQ-004 SHALL have parameter SoftRstCycles, default 8, per-hart soft-reset hold length (legal 1..255).
REQ-005 SHALL have port clk_i, input, 1, clock; all state is rising-edge.
REQ-006 SHALL have port reset_l, input, 1, reset: asynchronous, active-low.
REQ-007 SHALL have port spc_grst_l, output, 1, registered copy of reset_l for the tile testbench hierarchy.
REQ-008 SHALL have port hart_rstn_o, output, NHarts, per-hart active-low core reset.
REQ-009 SHALL have port soft_rst_req_i, input, NHarts, per-hart soft-reset request (level; rising edge acts).
REQ-010 SHALL have port soft_rst_ack_o, output, NHarts, one-cycle pulse on soft-reset completion.
REQ-011 SHALL have port all_awake_o, output, 1, high once every hart has been released after power-on.

Function
REQ-012 SHALL count edges after reset_l deassertion in a WakeCntWidth-bit counter saturating when its MSB is set; wake_done = MSB, reached after 2^(WakeCntWidth-1) edges.
REQ-013 SHALL run a global FSM WAKE -> STAGGER -> RUN: WAKE leaves on wake_done; STAGGER releases hart index 0..NHarts-1 in order; RUN is terminal until reset.
REQ-014 SHALL drive hart_rstn_o[0] high at edge 2^(WakeCntWidth-1)+1 and hart_rstn_o[i] high exactly i*StaggerCycles edges later.
REQ-015 SHALL assert all_awake_o on the same edge as the last hart release and hold it until reset.
REQ-016 SHALL run per hart an FSM HOLD -> RUN -> SRST -> RUN; hart_rstn_o[i] is high only in RUN.
REQ-017 SHALL detect a soft-reset request as soft_rst_req_i[i] sampled high at edge k and low at edge k-1, and accept it only when hart i is in RUN.
REQ-018 SHALL, for a request accepted at edge k, drive hart_rstn_o[i] low after edge k and high again after edge k+SoftRstCycles, with soft_rst_ack_o[i] high for exactly that one cycle.
REQ-019 SHALL ignore request rising edges while the hart is in HOLD or SRST; a level held high across completion SHALL NOT retrigger.
REQ-020 SHALL handle soft resets on different harts, including simultaneous ones, independently with no cross-hart effect.
REQ-021 SHALL NOT alter all_awake_o or the global FSM on a soft reset.
REQ-022 SHALL drive every hart_rstn_o bit through a flop (no combinational path from soft_rst_req_i).
REQ-023 SHALL size the stagger and soft-reset counters as $clog2(max+1) bits with no wrap-around before terminal count.

Reset
REQ-024 SHALL, on reset_l low, asynchronously force hart_rstn_o = 0, soft_rst_ack_o = 0, all_awake_o = 0, spc_grst_l = 0, all counters 0 and all FSMs to WAKE/HOLD, including mid-stagger or mid-soft-reset.
REQ-025 SHALL drive spc_grst_l high on the first rising edge after reset_l deassertion.
REQ-026 SHALL start the wake count only after reset_l deassertion; no reset_l synchronizer is inside the block.

Structure
REQ-027 SHALL place the global and per-hart FSM state enums and parameter legal-range constants in drac_pkg.
REQ-028 SHALL implement the per-hart FSM, edge detector and soft-reset counter as sub-module drac_hart_rst_fsm, instantiated NHarts times via generate.
REQ-029 SHALL check parameter legality with elaboration-time assertions.

Verification
REQ-030 SHALL cover power-on release: NHarts=3, WakeCntWidth=4, StaggerCycles=2, reset_l released before edge 1 -> hart_rstn_o rises at edges 9, 11, 13; all_awake_o rises at edge 13.
REQ-031 SHALL cover soft reset: SoftRstCycles=3, req rises sampled at edge 20 on hart 1 -> hart_rstn_o[1] low after edges 20..22, high after edge 23, ack pulse one cycle; harts 0 and 2 stay high.
REQ-032 SHALL cover ignored requests: req[2] raised at edge 10 (hart 2 in HOLD) and held high -> no SRST entry and no ack ever.
REQ-033 SHALL cover simultaneous requests: req[0] and req[2] both rise at edge 30 -> both release after edge 30+SoftRstCycles, with acks in the same cycle.
REQ-034 SHALL cover mid-operation reset: reset_l low at edge 12 (mid-stagger) -> all outputs 0 immediately; after re-release the full sequence of REQ-030 repeats from edge 1.
REQ-035 SHALL cover the NHarts=1 degenerate case: NHarts=1, StaggerCycles=255 -> hart 0 released at edge 2^(WakeCntWidth-1)+1 and all_awake_o asserted in the same cycle.
